// File: rtl/roi_pass_gate_if.sv
// Bus bundle for roi_pass_gate: pixel stream in, ROI config in, pass results out.
//   slave  : the gate (consumes pixels/config, drives results)
//   master : the producer/consumer side (coordinate generator + detectors, or a bench)
// Signals:
//   pix_valid, field, tv_x, tv_y                        pixel stream
//   cfg_we, cfg_idx, cfg_x1, cfg_y1, cfg_x2, cfg_y2     pending-bank ROI write
//   out_valid, pass, pass_x, pass_y, end_field          registered results
//   pass_cnt                                            per-ROI counts (PASS_COUNT_EN only)
interface roi_pass_gate_if #(
  parameter int unsigned CW   = 10,
  parameter int unsigned NROI = 2
);
  logic               pix_valid;
  logic               field;
  logic [CW-1:0]      tv_x;
  logic [CW-1:0]      tv_y;
  logic               cfg_we;
  logic [2:0]         cfg_idx;
  logic [CW-1:0]      cfg_x1;
  logic [CW-1:0]      cfg_y1;
  logic [CW-1:0]      cfg_x2;
  logic [CW-1:0]      cfg_y2;
  logic               out_valid;
  logic [NROI-1:0]    pass;
  logic [NROI*CW-1:0] pass_x;
  logic [CW-1:0]      pass_y;
  logic               end_field;
`ifdef PASS_COUNT_EN
  logic [NROI*2*CW-1:0] pass_cnt;
`endif

  modport slave (
`ifdef PASS_COUNT_EN
    output pass_cnt,
`endif
    input  pix_valid, field, tv_x, tv_y,
    input  cfg_we, cfg_idx, cfg_x1, cfg_y1, cfg_x2, cfg_y2,
    output out_valid, pass, pass_x, pass_y, end_field
  );

  modport master (
`ifdef PASS_COUNT_EN
    input  pass_cnt,
`endif
    output pix_valid, field, tv_x, tv_y,
    output cfg_we, cfg_idx, cfg_x1, cfg_y1, cfg_x2, cfg_y2,
    input  out_valid, pass, pass_x, pass_y, end_field
  );
endinterface

// File: rtl/roi_pass_gate.sv
// Multi-region video pass gate. Each valid pixel is tested against NROI rectangles; per-ROI
// pass flags and ROI-relative X come out one clock later. A one-shot end_field pulse fires once
// the scan of the active field has moved END_MARGIN lines past the lowest ROI.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (clears config banks too)
//   bus    roi_pass_gate_if.slave (pixel stream, ROI config writes, results)
// Optional feature: define PASS_COUNT_EN to add per-ROI saturating pass counters (bus.pass_cnt).
module roi_pass_gate #(
  parameter int unsigned CW         = 10,
  parameter int unsigned NROI       = 2,
  parameter int unsigned END_MARGIN = 4,
  parameter bit          FIELD_SEL  = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  roi_pass_gate_if.slave bus
);

  localparam logic [CW:0] Margin = (CW+1)'(END_MARGIN);

  typedef enum logic [1:0] {StWait, StActive, StDone} state_e;

  state_e r_state, w_state_d;

  logic [CW-1:0] r_pend_x1 [NROI];
  logic [CW-1:0] r_pend_y1 [NROI];
  logic [CW-1:0] r_pend_x2 [NROI];
  logic [CW-1:0] r_pend_y2 [NROI];
  logic [CW-1:0] r_act_x1  [NROI];
  logic [CW-1:0] r_act_y1  [NROI];
  logic [CW-1:0] r_act_x2  [NROI];
  logic [CW-1:0] r_act_y2  [NROI];
  logic [CW:0]   r_ymax_end;

  logic               r_out_valid;
  logic [NROI-1:0]    r_pass;
  logic [NROI*CW-1:0] r_pass_x;
  logic [CW-1:0]      r_pass_y;
  logic               r_end_field;

  logic            w_commit;
  logic            w_gate;
  logic            w_fire;
  logic [CW:0]     w_ymax_new;
  logic            w_any_valid;
  logic [NROI-1:0] w_hit;
  logic [CW-1:0]   w_x1  [NROI];
  logic [CW-1:0]   w_rel [NROI];

  // FSM next state; only a valid pixel advances it.
  always_comb begin
    w_state_d = r_state;
    w_commit  = 1'b0;
    w_gate    = 1'b0;
    w_fire    = 1'b0;
    if (bus.pix_valid) begin
      unique case (r_state)
        StWait: begin
          if (bus.field == FIELD_SEL) begin
            w_state_d = StActive;
            w_commit  = 1'b1;
            w_gate    = 1'b1;
          end
        end
        StActive: begin
          if (bus.field != FIELD_SEL) begin
            w_state_d = StWait;
          end else if ({1'b0, bus.tv_y} > r_ymax_end) begin
            w_state_d = StDone;
            w_fire    = 1'b1;
          end else begin
            w_gate = 1'b1;
          end
        end
        StDone: begin
          if (bus.field != FIELD_SEL) w_state_d = StWait;
        end
        default: w_state_d = StWait;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StWait;
    else        r_state <= w_state_d;
  end

  // Lowest end line over the pending bank, evaluated for the commit.
  always_comb begin
    w_ymax_new  = '0;
    w_any_valid = 1'b0;
    for (int i = 0; i < int'(NROI); i++) begin
      if (r_pend_x1[i] <= r_pend_x2[i] && r_pend_y1[i] <= r_pend_y2[i]) begin
        w_any_valid = 1'b1;
        if ({1'b0, r_pend_y2[i]} + Margin > w_ymax_new) w_ymax_new = {1'b0, r_pend_y2[i]} + Margin;
      end
    end
    if (!w_any_valid) w_ymax_new = '1;
  end

  // The entry pixel compares against the bank being committed on this same edge.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < int'(NROI); i++) begin
      w_x1[i]  = w_commit ? r_pend_x1[i] : r_act_x1[i];
      w_rel[i] = bus.tv_x - w_x1[i];
      w_hit[i] = w_gate
          && (w_x1[i] <= bus.tv_x)
          && (bus.tv_x <= (w_commit ? r_pend_x2[i] : r_act_x2[i]))
          && ((w_commit ? r_pend_y1[i] : r_act_y1[i]) <= bus.tv_y)
          && (bus.tv_y <= (w_commit ? r_pend_y2[i] : r_act_y2[i]));
    end
  end

  // Config banks. A write coinciding with the commit lands in pending only (NBA ordering).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NROI); i++) begin
        r_pend_x1[i] <= '0;
        r_pend_y1[i] <= '0;
        r_pend_x2[i] <= '0;
        r_pend_y2[i] <= '0;
        r_act_x1[i]  <= '0;
        r_act_y1[i]  <= '0;
        r_act_x2[i]  <= '0;
        r_act_y2[i]  <= '0;
      end
      r_ymax_end <= '0;
    end else begin
      for (int i = 0; i < int'(NROI); i++) begin
        if (bus.cfg_we && bus.cfg_idx == 3'(i)) begin
          r_pend_x1[i] <= bus.cfg_x1;
          r_pend_y1[i] <= bus.cfg_y1;
          r_pend_x2[i] <= bus.cfg_x2;
          r_pend_y2[i] <= bus.cfg_y2;
        end
        if (w_commit) begin
          r_act_x1[i] <= r_pend_x1[i];
          r_act_y1[i] <= r_pend_y1[i];
          r_act_x2[i] <= r_pend_x2[i];
          r_act_y2[i] <= r_pend_y2[i];
        end
      end
      if (w_commit) r_ymax_end <= w_ymax_new;
    end
  end

  // Result registers; pass_x keeps its value across invalid cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_pass      <= '0;
      r_pass_x    <= '0;
      r_pass_y    <= '0;
      r_end_field <= 1'b0;
    end else begin
      r_out_valid <= bus.pix_valid;
      r_end_field <= w_fire;
      if (bus.pix_valid) begin
        r_pass   <= w_hit;
        r_pass_y <= (|w_hit) ? bus.tv_y : '0;
        for (int i = 0; i < int'(NROI); i++) begin
          r_pass_x[i*CW +: CW] <= w_hit[i] ? w_rel[i] : '0;
        end
      end else begin
        r_pass   <= '0;
        r_pass_y <= '0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.pass      = r_pass;
  assign bus.pass_x    = r_pass_x;
  assign bus.pass_y    = r_pass_y;
  assign bus.end_field = r_end_field;

`ifdef PASS_COUNT_EN
  localparam logic [2*CW-1:0] CntMax = '1;
  localparam logic [2*CW-1:0] CntOne = (2*CW)'(1);

  logic [NROI*2*CW-1:0] r_pass_cnt;

  // Counts registered pass bits; pass is 0 outside ACTIVE so the count holds in WAIT/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= '0;
    end else if (w_commit) begin
      r_pass_cnt <= '0;
    end else begin
      for (int i = 0; i < int'(NROI); i++) begin
        if (r_pass[i] && r_pass_cnt[i*2*CW +: 2*CW] != CntMax) begin
          r_pass_cnt[i*2*CW +: 2*CW] <= r_pass_cnt[i*2*CW +: 2*CW] + CntOne;
        end
      end
    end
  end

  assign bus.pass_cnt = r_pass_cnt;
`else
  // Counter feature not built.
`endif

endmodule

// File: tb/tb_roi_pass_gate.sv
module tb_roi_pass_gate;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  roi_pass_gate_if #(.CW(10), .NROI(2)) bus ();

  roi_pass_gate #(
    .CW        (10),
    .NROI      (2),
    .END_MARGIN(4),
    .FIELD_SEL (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel cycle; results are sampled 1 time unit after the capturing edge.
  task automatic pix(input logic v, input logic f, input int x, input int y);
    @(negedge clk);
    bus.pix_valid = v;
    bus.field     = f;
    bus.tv_x      = 10'(x);
    bus.tv_y      = 10'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input int x1, input int y1, input int x2, input int y2);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = 3'(idx);
    bus.cfg_x1    = 10'(x1);
    bus.cfg_y1    = 10'(y1);
    bus.cfg_x2    = 10'(x2);
    bus.cfg_y2    = 10'(y2);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.field     = 1'b1;
    bus.tv_x      = '0;
    bus.tv_y      = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_x1    = '0;
    bus.cfg_y1    = '0;
    bus.cfg_x2    = '0;
    bus.cfg_y2    = '0;

    // Reset held while pixels toggle.
    for (int i = 0; i < 4; i++) pix(i[0], 1'b1, 0, 0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_pass", 64'(bus.pass), 64'd0);
    chk("rst_pass_x", 64'(bus.pass_x), 64'd0);
    chk("rst_pass_y", 64'(bus.pass_y), 64'd0);
    chk("rst_end_field", 64'(bus.end_field), 64'd0);
`ifdef PASS_COUNT_EN
    chk("rst_pass_cnt", 64'(bus.pass_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Field 0 must not pass even though the reset ROI covers (0,0).
    pix(1'b1, 1'b0, 0, 0);
    chk("f0_out_valid", 64'(bus.out_valid), 64'd1);
    chk("f0_pass", 64'(bus.pass), 64'd0);

    cfg(0, 10, 5, 20, 8);
    cfg(1, 5, 0, 4, 0);          // x1>x2: never passes
    pix(1'b1, 1'b1, 15, 6);      // entry pixel
    chk("in_pass", 64'(bus.pass), 64'd1);
    chk("in_pass_x", 64'(bus.pass_x), 64'd5);
    chk("in_pass_y", 64'(bus.pass_y), 64'd6);
    chk("in_end", 64'(bus.end_field), 64'd0);
    pix(1'b1, 1'b1, 21, 6);
    chk("right_pass", 64'(bus.pass), 64'd0);
    chk("right_pass_y", 64'(bus.pass_y), 64'd0);
    pix(1'b1, 1'b1, 10, 5);
    chk("tl_pass", 64'(bus.pass), 64'd1);
    chk("tl_pass_x", 64'(bus.pass_x), 64'd0);
    pix(1'b1, 1'b1, 20, 8);
    chk("br_pass", 64'(bus.pass), 64'd1);
    chk("br_pass_x", 64'(bus.pass_x), 64'd10);
    chk("br_pass_y", 64'(bus.pass_y), 64'd8);
    pix(1'b0, 1'b1, 15, 6);
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_pass", 64'(bus.pass), 64'd0);
    chk("idle_pass_x_hold", 64'(bus.pass_x), 64'd10);

    // ROI1 written mid-field stays pending.
    cfg(1, 12, 4, 18, 7);
    pix(1'b1, 1'b1, 15, 6);
    chk("shadow_pass", 64'(bus.pass), 64'd1);
    pix(1'b1, 1'b1, 0, 12);
    chk("ymax_edge_end", 64'(bus.end_field), 64'd0);
    pix(1'b1, 1'b1, 0, 13);
    chk("ymax_fire_end", 64'(bus.end_field), 64'd1);
    pix(1'b1, 1'b1, 15, 6);
    chk("done_pass", 64'(bus.pass), 64'd0);
    chk("done_end_once", 64'(bus.end_field), 64'd0);

    // Next field: overlap of both ROIs.
    pix(1'b1, 1'b0, 15, 6);
    chk("wait_pass", 64'(bus.pass), 64'd0);
    pix(1'b1, 1'b1, 15, 6);
    chk("ovl_pass", 64'(bus.pass), 64'd3);
    chk("ovl_pass_x", 64'(bus.pass_x), 64'd3077);   // {3, 5}
    chk("ovl_pass_y", 64'(bus.pass_y), 64'd6);

    // y2 moved to 30 mid-field: old end line (12) still governs this field.
    cfg(0, 10, 5, 20, 30);
    pix(1'b1, 1'b1, 15, 20);
    chk("old_y2_pass", 64'(bus.pass), 64'd0);
    chk("old_y2_end", 64'(bus.end_field), 64'd1);
    pix(1'b1, 1'b0, 0, 0);
    pix(1'b1, 1'b1, 15, 20);
    chk("new_y2_pass", 64'(bus.pass), 64'd1);
    chk("new_y2_pass_x", 64'(bus.pass_x), 64'd5);
    pix(1'b1, 1'b1, 0, 34);
    chk("y34_end", 64'(bus.end_field), 64'd0);
    pix(1'b1, 1'b1, 0, 35);
    chk("y35_end", 64'(bus.end_field), 64'd1);

    // Field drops before the end line: no end_field.
    pix(1'b1, 1'b0, 0, 0);
    pix(1'b1, 1'b1, 0, 0);
    chk("tog_entry_pass", 64'(bus.pass), 64'd0);
    pix(1'b1, 1'b0, 0, 40);
    chk("tog_end", 64'(bus.end_field), 64'd0);

    // y2=1022: end line 1026 must not wrap.
    cfg(0, 0, 0, 1023, 1022);
    cfg(1, 5, 0, 4, 0);
    pix(1'b1, 1'b1, 3, 1022);
    chk("big_pass", 64'(bus.pass), 64'd1);
    chk("big_pass_x", 64'(bus.pass_x), 64'd3);
    chk("big_pass_y", 64'(bus.pass_y), 64'd1022);
    pix(1'b1, 1'b1, 0, 1023);
    chk("big_nowrap_end", 64'(bus.end_field), 64'd0);
    chk("big_y1023_pass", 64'(bus.pass), 64'd0);

    // Asynchronous reset while ACTIVE.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_pass", 64'(bus.pass), 64'd0);
    chk("arst_pass_x", 64'(bus.pass_x), 64'd0);
    chk("arst_pass_y", 64'(bus.pass_y), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Pending lost: both ROIs back to (0,0); commit from WAIT, end line 4.
    pix(1'b1, 1'b1, 0, 0);
    chk("post_rst_pass", 64'(bus.pass), 64'd3);
    chk("post_rst_pass_y", 64'(bus.pass_y), 64'd0);
    pix(1'b1, 1'b1, 0, 5);
    chk("post_rst_end", 64'(bus.end_field), 64'd1);

`ifdef PASS_COUNT_EN
    cfg(0, 2, 2, 4, 5);          // 3x4 window, end line 9
    cfg(1, 5, 0, 4, 0);
    pix(1'b1, 1'b0, 0, 0);
    for (int y = 0; y <= 10; y++) begin
      for (int x = 0; x <= 6; x++) pix(1'b1, 1'b1, x, y);
    end
    pix(1'b0, 1'b1, 0, 0);
    pix(1'b0, 1'b1, 0, 0);
    chk("cnt_after_end", 64'(bus.pass_cnt), 64'd12);
    pix(1'b1, 1'b1, 3, 3);
    chk("cnt_done_hold", 64'(bus.pass_cnt), 64'd12);
    pix(1'b1, 1'b0, 0, 0);
    chk("cnt_wait_hold", 64'(bus.pass_cnt), 64'd12);
    pix(1'b1, 1'b1, 0, 0);
    chk("cnt_clear", 64'(bus.pass_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
